// File: rtl/pc_sequencer.sv
// Word-aligned PC[15:2] sequencer driving an external 14-bit adder; BOOT/RUN/HALT FSM.
// Optional feature: define PC_OVF_TRAP_EN to redirect wrapping updates to TRAP_PC and pulse trap.
module pc_sequencer #(
  parameter logic [13:0] RESET_PC = 14'h0000,
  parameter logic [13:0] TRAP_PC  = 14'h3FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [13:0] fetch_pc,
  input  logic        br_valid,
  input  logic [13:0] br_base,
  input  logic [13:0] br_offset,
  input  logic        halt_req,
  output logic [13:0] add_a,
  output logic [13:0] add_b,
  input  logic [13:0] add_s,
  input  logic        add_cout,
  output logic        pc_wrap,
  output logic        trap,
  output logic [1:0]  dbg_state
);

`ifdef PC_OVF_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] pc_q, pc_d;
  logic        fv_q, fv_d;
  logic        wrap_q, wrap_d;
  logic        trap_q, trap_d;
  logic        br_take, fire, upd;

  // Handshake: fetch_pc is transferred on a cycle where fetch_valid and fetch_ready
  // are both high; while valid is high and ready low, fetch_pc holds unless a redirect lands.
  always_comb begin
    br_take = br_valid && (state_q != S_BOOT);
    fire    = fv_q & fetch_ready;
    upd     = br_take | fire;
    add_a   = br_valid ? br_base : pc_q;
    add_b   = br_valid ? br_offset : 14'd1;
    state_d = halt_req ? S_HALT : S_RUN;
    fv_d    = ~halt_req;
    pc_d    = pc_q;
    wrap_d  = wrap_q | (upd & add_cout);
    trap_d  = 1'b0;
    if (upd) begin
      if (TrapEn && add_cout) begin
        pc_d   = TRAP_PC;
        trap_d = 1'b1;
      end else begin
        pc_d = add_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      wrap_q  <= wrap_d;
      trap_q  <= trap_d;
    end
  end

  assign fetch_valid = fv_q;
  assign fetch_pc    = pc_q;
  assign pc_wrap     = wrap_q;
  assign trap        = trap_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against an integer-level model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [13:0] fetch_pc;
  logic        br_valid;
  logic [13:0] br_base;
  logic [13:0] br_offset;
  logic        halt_req;
  logic [13:0] add_a;
  logic [13:0] add_b;
  logic [13:0] add_s;
  logic        add_cout;
  logic        pc_wrap;
  logic        trap;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef PC_OVF_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif
  localparam int ResetPc = 0;
  localparam int TrapPc  = 16383;

  // Reference model state, kept as plain integers and flags.
  int  m_pc;
  bit  m_boot;
  bit  m_offer;
  bit  m_wrap;
  bit  m_trap;
  logic [13:0] exp_q[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .br_valid(br_valid), .br_base(br_base), .br_offset(br_offset),
    .halt_req(halt_req),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .pc_wrap(pc_wrap), .trap(trap), .dbg_state(dbg_state)
  );

  // External 14-bit adder: sum and carry-out out of the top bit.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = ResetPc; m_boot = 1'b1; m_offer = 1'b0; m_wrap = 1'b0; m_trap = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_cycle(input bit br, input int base, input int off, input bit halt, input bit rdy);
    int sum;
    bit upd;
    upd = 1'b0; sum = 0; m_trap = 1'b0;
    if (br && !m_boot) begin
      sum = base + off; upd = 1'b1;
    end else if (m_offer && rdy) begin
      sum = m_pc + 1; upd = 1'b1;
    end
    if (upd) begin
      m_pc = sum % 16384;
      if (sum >= 16384) begin
        m_wrap = 1'b1;
        if (TrapEn) begin
          m_pc = TrapPc; m_trap = 1'b1;
        end
      end
    end
    m_boot  = 1'b0;
    m_offer = !halt;
    exp_q.push_back(14'(m_pc));
  endtask

  // Called at a falling edge: drive, check operands, clock, check registered outputs.
  task automatic step(input bit br, input logic [13:0] base, input logic [13:0] off,
                      input bit halt, input bit rdy);
    logic [13:0] exp_pc;
    br_valid = br; br_base = base; br_offset = off; halt_req = halt; fetch_ready = rdy;
    #1;
    check("add_a", 16'(add_a), 16'(br ? int'(base) : m_pc));
    check("add_b", 16'(add_b), 16'(br ? int'(off) : 1));
    @(posedge clk);
    model_cycle(br, int'(base), int'(off), halt, rdy);
    @(negedge clk);
    exp_pc = exp_q.pop_front();
    check("fetch_pc", 16'(fetch_pc), 16'(exp_pc));
    check("fetch_valid", 16'(fetch_valid), 16'(m_offer));
    check("pc_wrap", 16'(pc_wrap), 16'(m_wrap));
    check("trap", 16'(trap), 16'(m_trap));
  endtask

  task automatic apply_reset();
    br_valid = 1'b0; br_base = '0; br_offset = '0; halt_req = 1'b0; fetch_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fetch_valid", 16'(fetch_valid), 16'(0));
    check("rst_fetch_pc", 16'(fetch_pc), 16'(ResetPc));
    check("rst_pc_wrap", 16'(pc_wrap), 16'(0));
    check("rst_trap", 16'(trap), 16'(0));
    rst_n = 1'b1;
    model_reset();
    check("boot_state", 16'(dbg_state), 16'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    br_valid = 1'b0; br_base = '0; br_offset = '0; halt_req = 1'b0; fetch_ready = 1'b0;
    model_reset();

    // T1: boot cycle then sequential fetches 0,1,2,3
    apply_reset();
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    check("t1_first_pc", 16'(fetch_pc), 16'h0000);
    check("t1_first_valid", 16'(fetch_valid), 16'h0001);
    for (int i = 0; i < 3; i++) step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    check("t1_pc3", 16'(fetch_pc), 16'h0003);

    // T2: backpressure at pc=5
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
    check("t2_held", 16'(fetch_pc), 16'h0005);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    check("t2_adv", 16'(fetch_pc), 16'h0006);

    // T3: negative-offset branch with carry-out
    step(1'b1, 14'h0010, 14'h3FFC, 1'b0, 1'b0);
    check("t3_pc", 16'(fetch_pc), TrapEn ? 16'(TrapPc) : 16'h000C);
    check("t3_wrap", 16'(pc_wrap), 16'h0001);

    // Branch during BOOT is ignored; then T4 sequential wrap from 3FFF
    apply_reset();
    step(1'b1, 14'h0100, 14'h0005, 1'b0, 1'b1);
    check("boot_br_ignored", 16'(fetch_pc), 16'h0000);
    step(1'b1, 14'h3FFF, 14'h0000, 1'b0, 1'b0);
    check("t4_at_top", 16'(fetch_pc), 16'h3FFF);
    check("t4_nowrap", 16'(pc_wrap), 16'h0000);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    check("t4_wrap_pc", 16'(fetch_pc), TrapEn ? 16'(TrapPc) : 16'h0000);
    check("t4_trap", 16'(trap), 16'(TrapEn));
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
    check("t4_trap_drop", 16'(trap), 16'h0000);

    // T5: branch and halt together
    step(1'b1, 14'h0008, 14'h0002, 1'b1, 1'b1);
    check("t5_pc", 16'(fetch_pc), 16'h000A);
    check("t5_halted", 16'(fetch_valid), 16'h0000);
    step(1'b0, 14'h0, 14'h0, 1'b1, 1'b1);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    check("t5_resume_pc", 16'(fetch_pc), 16'h000A);
    check("t5_resume_valid", 16'(fetch_valid), 16'h0001);

    // T6: asynchronous reset mid-cycle at pc=7
    step(1'b1, 14'h0007, 14'h0000, 1'b0, 1'b0);
    check("t6_pc7", 16'(fetch_pc), 16'h0007);
    br_valid = 1'b0; fetch_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 16'(fetch_valid), 16'h0000);
    check("t6_async_pc", 16'(fetch_pc), 16'(ResetPc));
    check("t6_async_wrap", 16'(pc_wrap), 16'h0000);
    @(negedge clk);
    apply_reset();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 3) == 0, 14'($urandom), 14'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
